// File: rtl/csr_access_unit.sv
`default_nettype none
// ============================================================================
// Module      : csr_access_unit
// Description : Initiator side of the CSR register-file port. Executes Zicsr
//               instructions (CSRRW/RS/RC and immediate forms) as a sequenced
//               read-modify-write: accept, read old value, write new value,
//               return old value for rd.
//
// Ports       : clk_i, resetN_i            clock / async active-low reset
//               reqValid_i, reqReady_o     request handshake
//               reqFunct3_i, reqAddr_i     instruction funct3, CSR address
//               reqRs1Data_i, reqUimm_i,   register / immediate operand and
//               reqRs1Zero_i               "rs1 is x0" flag
//               csrRAddr_o, csrRData_i     register-file read port
//               csrWAddr_o, csrWData_o,    register-file write port
//               csrWEn_o
//               rspValid_o, rspReady_i     response handshake
//               rspData_o, rspIllegal_o    old CSR value, illegal flag
//
// Build option: CSR_RO_CHECK_EN - when defined, any request that would write
//               a CSR with address[11:10]==2'b11 is reported illegal and no
//               write is issued.
//
// Revision    : 1.0 - initial release
// ============================================================================
module csr_access_unit (
    input  logic        clk_i,
    input  logic        resetN_i,
    input  logic        reqValid_i,
    output logic        reqReady_o,
    input  logic [2:0]  reqFunct3_i,
    input  logic [11:0] reqAddr_i,
    input  logic [31:0] reqRs1Data_i,
    input  logic [4:0]  reqUimm_i,
    input  logic        reqRs1Zero_i,
    output logic [11:0] csrRAddr_o,
    input  logic [31:0] csrRData_i,
    output logic [11:0] csrWAddr_o,
    output logic [31:0] csrWData_o,
    output logic        csrWEn_o,
    output logic        rspValid_o,
    input  logic        rspReady_i,
    output logic [31:0] rspData_o,
    output logic        rspIllegal_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_stateNext;

    logic [2:0]  r_funct3;
    logic [11:0] r_addr;
    logic [31:0] r_rs1Data;
    logic [4:0]  r_uimm;
    logic        r_rs1Zero;
    logic [31:0] r_oldValue;

    logic        w_accept;
    logic [31:0] w_src;
    logic        w_isReserved;
    logic        w_isRw;
    logic        w_isSet;
    logic        w_opZero;
    logic        w_wouldWrite;
    logic        w_roViolation;
    logic        w_illegal;
    logic        w_doWrite;
    logic [31:0] w_newValue;

    assign w_accept = reqValid_i && (r_state == ST_IDLE);

    // ------------------------------------------------------------------------
    // State and request registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge resetN_i) begin
        if (!resetN_i) begin
            r_state    <= ST_IDLE;
            r_funct3   <= 3'b000;
            r_addr     <= 12'h000;
            r_rs1Data  <= 32'h0000_0000;
            r_uimm     <= 5'b00000;
            r_rs1Zero  <= 1'b0;
            r_oldValue <= 32'h0000_0000;
        end else begin
            r_state <= w_stateNext;
            if (w_accept) begin
                r_funct3  <= reqFunct3_i;
                r_addr    <= reqAddr_i;
                r_rs1Data <= reqRs1Data_i;
                r_uimm    <= reqUimm_i;
                r_rs1Zero <= reqRs1Zero_i;
            end
            // Register-file read data is combinational; capture it at the end
            // of READ so counters reflect their value during that cycle.
            if (r_state == ST_READ) begin
                r_oldValue <= csrRData_i;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Instruction decode (from latched request)
    // funct3[1:0]: 00 reserved, 01 write, 10 set, 11 clear; funct3[2] = imm
    // ------------------------------------------------------------------------
    assign w_src        = r_funct3[2] ? {27'b0, r_uimm} : r_rs1Data;
    assign w_isReserved = (r_funct3[1:0] == 2'b00);
    assign w_isRw       = (r_funct3[1:0] == 2'b01);
    assign w_isSet      = (r_funct3[1:0] == 2'b10);
    assign w_opZero     = r_funct3[2] ? (r_uimm == 5'b00000) : r_rs1Zero;

    // Set/clear with a zero operand index is a pure read: no write side effect.
    assign w_wouldWrite = !w_isReserved && (w_isRw || !w_opZero);

`ifdef CSR_RO_CHECK_EN
    assign w_roViolation = (r_addr[11:10] == 2'b11) && w_wouldWrite;
`else
    assign w_roViolation = 1'b0;
`endif

    assign w_illegal = w_isReserved || w_roViolation;
    assign w_doWrite = w_wouldWrite && !w_roViolation;

    always_comb begin
        w_newValue = w_src;
        if (w_isSet) begin
            w_newValue = r_oldValue | w_src;
        end else if (!w_isRw) begin
            w_newValue = r_oldValue & ~w_src;
        end
    end

    // ------------------------------------------------------------------------
    // Next state and outputs
    // ------------------------------------------------------------------------
    always_comb begin
        w_stateNext  = r_state;
        reqReady_o   = 1'b0;
        csrRAddr_o   = 12'h000;
        csrWAddr_o   = 12'h000;
        csrWData_o   = 32'h0000_0000;
        csrWEn_o     = 1'b0;
        rspValid_o   = 1'b0;
        rspData_o    = 32'h0000_0000;
        rspIllegal_o = 1'b0;

        case (r_state)
            ST_IDLE: begin
                reqReady_o = 1'b1;
                if (reqValid_i) begin
                    w_stateNext = ST_READ;
                end
            end
            ST_READ: begin
                csrRAddr_o  = r_addr;
                w_stateNext = ST_WRITE;
            end
            ST_WRITE: begin
                if (w_doWrite) begin
                    csrWEn_o   = 1'b1;
                    csrWAddr_o = r_addr;
                    csrWData_o = w_newValue;
                end
                w_stateNext = ST_RESP;
            end
            ST_RESP: begin
                rspValid_o   = 1'b1;
                rspIllegal_o = w_illegal;
                rspData_o    = w_illegal ? 32'h0000_0000 : r_oldValue;
                if (rspReady_i) begin
                    w_stateNext = ST_IDLE;
                end
            end
            default: begin
                w_stateNext = ST_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_csr_access_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_csr_access_unit
// Description : Self-checking bench for csr_access_unit. A simple CSR
//               register file (with a free-running cycle counter at 0xC00)
//               answers the unit; expected results come from a reference
//               array updated with the Zicsr rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_csr_access_unit;

    logic        clk_i;
    logic        resetN_i;
    logic        reqValid_i;
    logic        reqReady_o;
    logic [2:0]  reqFunct3_i;
    logic [11:0] reqAddr_i;
    logic [31:0] reqRs1Data_i;
    logic [4:0]  reqUimm_i;
    logic        reqRs1Zero_i;
    logic [11:0] csrRAddr_o;
    logic [31:0] csrRData_i;
    logic [11:0] csrWAddr_o;
    logic [31:0] csrWData_o;
    logic        csrWEn_o;
    logic        rspValid_o;
    logic        rspReady_i;
    logic [31:0] rspData_o;
    logic        rspIllegal_o;

    int errors = 0;
    int checks = 0;

    logic [31:0] cyc;
    logic        clr;
    logic [31:0] regfile [0:4095];
    logic [31:0] ref_mem [0:4095];

    csr_access_unit dut (
        .clk_i        (clk_i),
        .resetN_i     (resetN_i),
        .reqValid_i   (reqValid_i),
        .reqReady_o   (reqReady_o),
        .reqFunct3_i  (reqFunct3_i),
        .reqAddr_i    (reqAddr_i),
        .reqRs1Data_i (reqRs1Data_i),
        .reqUimm_i    (reqUimm_i),
        .reqRs1Zero_i (reqRs1Zero_i),
        .csrRAddr_o   (csrRAddr_o),
        .csrRData_i   (csrRData_i),
        .csrWAddr_o   (csrWAddr_o),
        .csrWData_o   (csrWData_o),
        .csrWEn_o     (csrWEn_o),
        .rspValid_o   (rspValid_o),
        .rspReady_i   (rspReady_i),
        .rspData_o    (rspData_o),
        .rspIllegal_o (rspIllegal_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Environment: plain storage register file plus a cycle counter at 0xC00.
    always @(posedge clk_i) begin
        cyc <= cyc + 32'd1;
        if (clr) begin
            for (int i = 0; i < 4096; i++) regfile[i] <= 32'h0;
        end else if (csrWEn_o) begin
            regfile[csrWAddr_o] <= csrWData_o;
        end
    end

    assign csrRData_i = (csrRAddr_o == 12'hC00) ? cyc : regfile[csrRAddr_o];

`ifdef CSR_RO_CHECK_EN
    localparam bit RO_CHECK = 1'b1;
`else
    localparam bit RO_CHECK = 1'b0;
`endif

    // One complete transaction with cycle-accurate checking against the model.
    task automatic run_req(input logic [2:0] f3, input logic [11:0] addr,
                           input logic [31:0] rs1, input logic [4:0] uimm,
                           input logic rs1z, input int delay, input string name);
        logic [31:0] old, src, nv, rd_exp;
        logic legal, is_rw, opz, would, illegal, wr;
        @(negedge clk_i);
        checks++;
        if (reqReady_o !== 1'b1) begin
            errors++; $display("FAIL %s idle_ready: got %b want 1", name, reqReady_o);
        end
        reqValid_i   = 1'b1;
        reqFunct3_i  = f3;
        reqAddr_i    = addr;
        reqRs1Data_i = rs1;
        reqUimm_i    = uimm;
        reqRs1Zero_i = rs1z;
        rspReady_i   = (delay == 0);
        @(posedge clk_i); #1;
        // Scramble request fields: the unit must use its latched copy.
        reqValid_i   = 1'b0;
        reqFunct3_i  = 3'($urandom);
        reqAddr_i    = 12'($urandom);
        reqRs1Data_i = $urandom;
        reqUimm_i    = 5'($urandom);
        reqRs1Zero_i = 1'($urandom);

        // Reference model, from the instruction semantics.
        old     = (addr == 12'hC00) ? cyc : ref_mem[addr];
        legal   = (f3 != 3'd0) && (f3 != 3'd4);
        src     = (f3 >= 3'd4) ? {27'd0, uimm} : rs1;
        is_rw   = (f3 == 3'd1) || (f3 == 3'd5);
        opz     = (f3 >= 3'd4) ? (uimm == 5'd0) : rs1z;
        would   = legal && (is_rw || !opz);
        illegal = !legal || (RO_CHECK && (addr >= 12'hC00) && would);
        wr      = would && !illegal;
        if (is_rw)                        nv = src;
        else if (f3 == 3'd2 || f3 == 3'd6) nv = old | src;
        else                              nv = old & ~src;
        rd_exp  = illegal ? 32'h0 : old;

        // READ cycle
        checks++;
        if (csrRAddr_o !== addr || csrWEn_o !== 1'b0 || reqReady_o !== 1'b0 || rspValid_o !== 1'b0) begin
            errors++;
            $display("FAIL %s read_cycle: raddr=%h wen=%b rdy=%b rv=%b want raddr=%h wen=0 rdy=0 rv=0",
                     name, csrRAddr_o, csrWEn_o, reqReady_o, rspValid_o, addr);
        end

        // WRITE cycle
        @(posedge clk_i); #1;
        checks++;
        if (csrWEn_o !== wr || csrWAddr_o !== (wr ? addr : 12'h0) ||
            csrWData_o !== (wr ? nv : 32'h0) || rspValid_o !== 1'b0 || reqReady_o !== 1'b0) begin
            errors++;
            $display("FAIL %s write: wen=%b waddr=%h wdata=%h rv=%b want wen=%b waddr=%h wdata=%h rv=0",
                     name, csrWEn_o, csrWAddr_o, csrWData_o, rspValid_o, wr,
                     wr ? addr : 12'h0, wr ? nv : 32'h0);
        end
        if (wr && addr != 12'hC00) ref_mem[addr] = nv;

        // RESP, held for 'delay' cycles
        for (int k = 0; k <= delay; k++) begin
            if (k == delay) rspReady_i = 1'b1;
            @(posedge clk_i); #1;
            if (k == 0) begin
                // First RESP observation comes two edges after the accept.
            end
            if (k < delay || k == 0) begin
                checks++;
                if (rspValid_o !== 1'b1 || rspData_o !== rd_exp || rspIllegal_o !== illegal ||
                    reqReady_o !== 1'b0 || csrWEn_o !== 1'b0) begin
                    errors++;
                    $display("FAIL %s resp[%0d]: rv=%b data=%h ill=%b rdy=%b wen=%b want rv=1 data=%h ill=%b rdy=0 wen=0",
                             name, k, rspValid_o, rspData_o, rspIllegal_o, reqReady_o, csrWEn_o,
                             rd_exp, illegal);
                end
            end
            if (k == 0 && delay == 0) break;
        end
        @(posedge clk_i); #1;
        rspReady_i = 1'b0;
        checks++;
        if (rspValid_o !== 1'b0 || reqReady_o !== 1'b1 || rspData_o !== 32'h0) begin
            errors++;
            $display("FAIL %s complete: rv=%b rdy=%b data=%h want rv=0 rdy=1 data=0",
                     name, rspValid_o, reqReady_o, rspData_o);
        end
    endtask

    task automatic check_reset_outputs(input string name);
        checks++;
        if (reqReady_o !== 1'b1 || rspValid_o !== 1'b0 || rspData_o !== 32'h0 ||
            rspIllegal_o !== 1'b0 || csrWEn_o !== 1'b0 || csrWAddr_o !== 12'h0 ||
            csrWData_o !== 32'h0 || csrRAddr_o !== 12'h0) begin
            errors++;
            $display("FAIL %s: rdy=%b rv=%b data=%h ill=%b wen=%b waddr=%h wdata=%h raddr=%h want 1,0,0,0,0,0,0,0",
                     name, reqReady_o, rspValid_o, rspData_o, rspIllegal_o, csrWEn_o,
                     csrWAddr_o, csrWData_o, csrRAddr_o);
        end
    endtask

    task automatic test_reset();
        resetN_i = 1'b0;
        clr      = 1'b1;
        repeat (3) @(posedge clk_i);
        #1;
        check_reset_outputs("reset_state");
        @(negedge clk_i);
        clr      = 1'b0;
        resetN_i = 1'b1;
        @(posedge clk_i); #1;
        check_reset_outputs("after_reset_idle");
    endtask

    task automatic test_fcsr_rw();
        run_req(3'b001, 12'h003, 32'h0000_0012, 5'd0, 1'b0, 1, "csrrw_fcsr_init");
        run_req(3'b001, 12'h003, 32'h0000_00A5, 5'd0, 1'b0, 0, "csrrw_fcsr_a5");
    endtask

    task automatic test_imm_zero();
        run_req(3'b001, 12'h002, 32'h0000_0003, 5'd0, 1'b0, 0, "csrrw_frm");
        run_req(3'b110, 12'h002, 32'hFFFF_FFFF, 5'd0, 1'b0, 2, "csrrsi_zero");
        run_req(3'b111, 12'h002, 32'h0, 5'd2, 1'b0, 0, "csrrci_frm");
    endtask

    task automatic test_set_clear();
        run_req(3'b001, 12'h001, 32'h0000_001F, 5'd0, 1'b0, 0, "csrrw_fflags");
        run_req(3'b011, 12'h001, 32'h0000_0005, 5'd0, 1'b0, 1, "csrrc_fflags");
        run_req(3'b010, 12'h001, 32'h0, 5'd0, 1'b1, 0, "csrrs_x0");
        run_req(3'b010, 12'h001, 32'h0000_0100, 5'd0, 1'b0, 0, "csrrs_fflags");
    endtask

    task automatic test_counter();
        run_req(3'b010, 12'hC00, 32'h0, 5'd0, 1'b1, 0, "csrrs_cycle_ro");
        run_req(3'b001, 12'hC00, 32'h1234_5678, 5'd0, 1'b0, 0, "csrrw_cycle");
        run_req(3'b101, 12'hF11, 32'h0, 5'd9, 1'b0, 0, "csrrwi_f11");
    endtask

    task automatic test_reserved();
        run_req(3'b100, 12'h003, 32'hDEAD_BEEF, 5'd7, 1'b0, 5, "reserved_100");
        run_req(3'b000, 12'h001, 32'h0000_00FF, 5'd0, 1'b0, 0, "reserved_000");
    endtask

    task automatic test_reset_mid();
        @(negedge clk_i);
        reqValid_i   = 1'b1;
        reqFunct3_i  = 3'b001;
        reqAddr_i    = 12'h340;
        reqRs1Data_i = 32'hCAFE_F00D;
        reqUimm_i    = 5'd0;
        reqRs1Zero_i = 1'b0;
        @(posedge clk_i); #1;
        reqValid_i = 1'b0;
        @(posedge clk_i); #1;
        // Unit is in WRITE with the strobe up; abort it.
        checks++;
        if (csrWEn_o !== 1'b1) begin
            errors++; $display("FAIL reset_mid_pre: wen=%b want 1", csrWEn_o);
        end
        resetN_i = 1'b0;
        #1;
        check_reset_outputs("reset_mid_immediate");
        repeat (2) begin
            @(posedge clk_i); #1;
            check_reset_outputs("reset_mid_held");
        end
        @(negedge clk_i);
        resetN_i = 1'b1;
        // Aborted write must not have landed.
        run_req(3'b010, 12'h340, 32'h0, 5'd0, 1'b1, 0, "after_reset_read");
        run_req(3'b001, 12'h340, 32'h0000_0077, 5'd0, 1'b0, 0, "after_reset_write");
    endtask

    task automatic test_random();
        logic [11:0] addrs [0:6];
        logic [2:0]  f3;
        logic        rz;
        logic [31:0] rs1;
        logic [4:0]  ui;
        addrs[0] = 12'h001; addrs[1] = 12'h002; addrs[2] = 12'h003; addrs[3] = 12'h300;
        addrs[4] = 12'h340; addrs[5] = 12'hC00; addrs[6] = 12'hF11;
        for (int n = 0; n < 40; n++) begin
            f3  = 3'($urandom);
            rz  = ($urandom_range(0, 3) == 0);
            rs1 = rz ? 32'h0 : $urandom;
            ui  = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
            run_req(f3, addrs[$urandom_range(0, 6)], rs1, ui, rz, $urandom_range(0, 3), "random");
        end
    endtask

    initial begin
        resetN_i     = 1'b0;
        clr          = 1'b1;
        cyc          = 32'h0;
        reqValid_i   = 1'b0;
        reqFunct3_i  = 3'b0;
        reqAddr_i    = 12'h0;
        reqRs1Data_i = 32'h0;
        reqUimm_i    = 5'd0;
        reqRs1Zero_i = 1'b0;
        rspReady_i   = 1'b0;
        for (int i = 0; i < 4096; i++) ref_mem[i] = 32'h0;

        test_reset();
        test_fcsr_rw();
        test_imm_zero();
        test_set_clear();
        test_counter();
        test_reserved();
        test_reset_mid();
        test_random();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Overall time limit so a stuck run still terminates.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
